// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial frame transmitter.
package serial_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts DIV cycles and flags the last cycle of each period.
module bit_timer
   import serial_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic clear,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   assign tick = (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clear || restart) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/serial_tx.sv
// Parallel-load frame transmitter: start bit, WIDTH data bits LSB first,
// optional even parity, stop bit; each bit held for DIV clocks.
module serial_tx
   import serial_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIV    = 4,
   parameter int PARITY = 0
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_in,
   input  logic             start,
   output logic             ready,
   output logic             tx,
   output logic             done
);

   localparam int IW = $clog2(WIDTH + 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic             par;
   logic [IW-1:0]    bit_idx;
   logic             tick;

   assign shreg_next = shreg >> 1;

   // Timer is held at zero while idle so the START bit gets a full period.
   bit_timer #(.DIV(DIV)) timer (
      .clk     (clk),
      .clear   (clear),
      .restart (state == IDLE),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         state   <= IDLE;
         tx      <= LINE_IDLE;
         ready   <= 1'b1;
         done    <= 1'b0;
         shreg   <= '0;
         par     <= 1'b0;
         bit_idx <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shreg   <= data_in;
                  par     <= ^data_in;
                  bit_idx <= '0;
                  tx      <= START_BIT;
                  ready   <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (tick) begin
                  tx    <= shreg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  shreg <= shreg_next;
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
                     if (PARITY != 0) begin
                        tx    <= par;
                        state <= PAR;
                     end else begin
                        tx    <= STOP_BIT;
                        state <= STOP;
                     end
                  end else begin
                     bit_idx <= bit_idx + IW'(1);
                     tx      <= shreg_next[0];
                  end
               end
            end
            PAR: begin
               if (tick) begin
                  tx    <= STOP_BIT;
                  state <= STOP;
               end
            end
            STOP: begin
               // Returning to IDLE here lets a start in the done cycle chain frames.
               if (tick) begin
                  tx    <= LINE_IDLE;
                  ready <= 1'b1;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               tx    <= LINE_IDLE;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx across three parameter sets, with a
// frame-level reference model and a decoding monitor.
module tb_serial_tx;

   typedef struct {
      logic [31:0] data;
      int          acc;
   } frame_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int W  = (g == 2) ? 1 : 8;
      localparam int P  = (g == 1) ? 1 : 0;
      localparam int D  = (g == 2) ? 1 : 4;
      localparam int N  = 2 + W + P;
      localparam int FL = N * D;

      logic         clear   = 1'b1;
      logic         start   = 1'b0;
      logic [W-1:0] data_in = '0;
      logic         ready, tx, done;
      bit           armed   = 1'b0;
      bit           fin     = 1'b0;

      serial_tx #(.WIDTH(W), .DIV(D), .PARITY(P)) dut (
         .clk     (clk),
         .clear   (clear),
         .data_in (data_in),
         .start   (start),
         .ready   (ready),
         .tx      (tx),
         .done    (done)
      );

      // Reference model: an accepted word becomes a list of line levels.
      logic   lvl_q[$];
      frame_t sb_q[$];
      logic   exp_tx = 1'b1, exp_ready = 1'b1, exp_done = 1'b0;

      always @(posedge clk) begin : model
         logic acc, had, pb;
         logic bits[$];
         if (clear) begin
            lvl_q.delete();
            sb_q.delete();
            exp_tx    = 1'b1;
            exp_ready = 1'b1;
            exp_done  = 1'b0;
         end else begin
            acc = exp_ready && start;
            had = (lvl_q.size() != 0);
            if (had) void'(lvl_q.pop_front());
            exp_done = had && (lvl_q.size() == 0);
            if (acc) begin
               pb = (($countones(data_in) % 2) == 1);
               bits.delete();
               bits.push_back(1'b0);
               for (int b = 0; b < W; b++) bits.push_back(data_in[b]);
               if (P != 0) bits.push_back(pb);
               bits.push_back(1'b1);
               foreach (bits[i]) repeat (D) lvl_q.push_back(bits[i]);
               sb_q.push_back('{32'(data_in), cyc + 1});
            end
            exp_ready = (lvl_q.size() == 0);
            exp_tx    = exp_ready ? 1'b1 : lvl_q[0];
         end
      end

      // Monitor: per-cycle line check plus whole-frame decode on each done.
      logic cap[$];

      always @(negedge clk) begin : mon
         frame_t      f;
         logic [31:0] ef, got;
         if (armed) begin
            check($sformatf("g%0d tx c%0d", g, cyc), tx, exp_tx);
            check($sformatf("g%0d ready c%0d", g, cyc), ready, exp_ready);
            check($sformatf("g%0d done c%0d", g, cyc), done, exp_done);
            if (done === 1'b1) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL g%0d unexpected_done actual=1 required=0", g);
               end else begin
                  f = sb_q.pop_front();
                  check($sformatf("g%0d latency", g), cyc - f.acc + 1, FL + 1);
                  check($sformatf("g%0d frame_len", g), cap.size(), FL);
                  if (cap.size() == FL) begin
                     got = '0;
                     for (int b = 0; b < N; b++) got[b] = cap[b*D + D/2];
                     ef = (f.data << 1) | (32'(1) << (N - 1));
                     ef = ef | (P != 0 ? (32'($countones(f.data) % 2) << (W + 1)) : 32'(0));
                     check($sformatf("g%0d frame_bits", g), got, ef);
                  end
               end
               cap.delete();
            end else if (ready === 1'b1) begin
               cap.delete();
            end else begin
               cap.push_back(tx);
            end
         end
      end

      task automatic wait_ready();
         int k = 0;
         while (ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
         end
         if (k >= 300) fail_now($sformatf("g%0d wait_ready", g));
      endtask

      task automatic wait_done();
         int k = 0;
         while (done !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
         end
         if (k >= 300) fail_now($sformatf("g%0d wait_done", g));
      endtask

      // Leaves the caller in the first cycle of the frame.
      task automatic send(input logic [W-1:0] d, output int acc);
         wait_ready();
         acc     = cyc + 1;
         start   = 1'b1;
         data_in = d;
         @(negedge clk);
         start   = 1'b0;
         data_in = W'($urandom);
      endtask

      task automatic reset_seq();
         clear = 1'b1;
         start = 1'b0;
         repeat (2) @(negedge clk);
         armed = 1'b1;
         check($sformatf("g%0d reset tx", g), tx, 1'b1);
         check($sformatf("g%0d reset ready", g), ready, 1'b1);
         check($sformatf("g%0d reset done", g), done, 1'b0);
         clear = 1'b0;
      endtask

      task automatic random_phase();
         int acc, r;
         for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(W'($urandom), acc);
            r = int'($urandom_range(0, 7));
            if (r == 0) begin
               repeat ($urandom_range(0, FL - 1)) @(negedge clk);
               clear = 1'b1;
               start = 1'(($urandom_range(0, 1)));
               @(negedge clk);
               clear = 1'b0;
               start = 1'b0;
            end else if (r < 3) begin
               repeat ($urandom_range(0, FL - 2)) @(negedge clk);
               start   = 1'b1;
               data_in = W'($urandom);
               @(negedge clk);
               start   = 1'b0;
               wait_done();
            end else begin
               wait_done();
            end
         end
         repeat (FL + 4) @(negedge clk);
      endtask

      if (g == 0) begin : dir
         initial begin
            int          acc, d1;
            logic [9:0]  lev;
            reset_seq();
            // A5 line levels, first bit sent at index 0.
            lev = 10'b1_1010_0101_0;
            send(8'hA5, acc);
            for (int i = 0; i < 40; i++) begin
               check($sformatf("A5 level %0d", i), tx, lev[i/4]);
               @(negedge clk);
            end
            check("A5 done at 41", done, 1'b1);
            check("A5 done cycle", cyc - acc + 1, 41);
            @(negedge clk);
            // start while busy is ignored
            send(8'h00, acc);
            repeat (16) @(negedge clk);
            start   = 1'b1;
            data_in = 8'hFF;
            repeat (8) @(negedge clk);
            start = 1'b0;
            wait_done();
            repeat (6) @(negedge clk);
            // back-to-back with start held high
            wait_ready();
            start   = 1'b1;
            data_in = 8'h01;
            @(negedge clk);
            data_in = 8'h80;
            wait_done();
            d1 = cyc;
            @(negedge clk);
            start = 1'b0;
            wait_done();
            check("b2b done spacing", cyc - d1, 41);
            @(negedge clk);
            // clear during data bit 3, with a same-cycle start that must be dropped
            send(8'h5A, acc);
            repeat (17) @(negedge clk);
            clear = 1'b1;
            start = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            start = 1'b0;
            check("clear tx", tx, 1'b1);
            check("clear ready", ready, 1'b1);
            check("clear done", done, 1'b0);
            send(8'hC3, acc);
            check("restart tx", tx, 1'b0);
            wait_done();
            random_phase();
            fin = 1'b1;
         end
      end else if (g == 1) begin : dir
         initial begin
            int         acc;
            logic [7:0] words [2];
            logic       pbit  [2];
            words = '{8'h07, 8'h03};
            pbit  = '{1'b1, 1'b0};
            reset_seq();
            for (int w = 0; w < 2; w++) begin
               send(words[w], acc);
               repeat (36) @(negedge clk);
               check($sformatf("parity bit %0h", words[w]), tx, pbit[w]);
               wait_done();
               check($sformatf("parity frame %0h", words[w]), cyc - acc + 1, 45);
               @(negedge clk);
            end
            random_phase();
            fin = 1'b1;
         end
      end else begin : dir
         initial begin
            int   acc;
            logic seq1 [3];
            logic seq0 [3];
            seq1 = '{1'b0, 1'b1, 1'b1};
            seq0 = '{1'b0, 1'b0, 1'b1};
            reset_seq();
            send(1'b1, acc);
            for (int i = 0; i < 3; i++) begin
               check($sformatf("w1 data1 level %0d", i), tx, seq1[i]);
               @(negedge clk);
            end
            check("w1 done 4th", done, 1'b1);
            @(negedge clk);
            send(1'b0, acc);
            for (int i = 0; i < 3; i++) begin
               check($sformatf("w1 data0 level %0d", i), tx, seq0[i]);
               @(negedge clk);
            end
            check("w1 done0 4th", done, 1'b1);
            random_phase();
            fin = 1'b1;
         end
      end
   end

   initial begin
      for (int k = 0; k < 60000 && !(cfg[0].fin && cfg[1].fin && cfg[2].fin); k++) begin
         @(posedge clk);
      end
      if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) fail_now("global_budget");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
